f3m_serial_mult: RTL

Digit-serial multiplier in GF(3^M) = GF(3)[x]/(x^M + x^TAP + 2). It computes C = A·B mod P, processing one GF(3) coefficient of B per clock, most-significant first. The M-cycle latency keeps the area near that of one add/scale row. It is the multiplicative counterpart of the subtract-and-scale division step used in the inversion datapath, and it sits beside that step in the pairing core as the low-area multiply for the Miller loop and final exponentiation.

---
 rtl/f3m_serial_mult_if.sv | 27 ++
 rtl/f3m_serial_mult.sv | 126 ++++++++++++
 2 files changed

// File: rtl/f3m_serial_mult_if.sv
// Request/result bundle for the GF(3^M) digit-serial multiplier.
// The master drives operands and the start request; the slave returns the product and done level.
interface f3m_serial_mult_if #(
    parameter int M = 97
);
    logic             start;
    logic [2*M-1:0]   A;
    logic [2*M-1:0]   B;
    logic [2*M-1:0]   C;
    logic             done;

    modport master (
        output start,
        output A,
        output B,
        input  C,
        input  done
    );

    modport slave (
        input  start,
        input  A,
        input  B,
        output C,
        output done
    );
endinterface

// File: rtl/f3m_serial_mult.sv
// Digit-serial multiplier in GF(3^M) = GF(3)[x]/(x^M + x^TAP + 2).
// One coefficient of B is consumed per clock, most significant first (Horner form):
// acc <- acc*x mod P + d*A. The product is ready M clocks after the start edge.
module f3m_serial_mult #(
    parameter int M   = 97,
    parameter int TAP = 12
) (
    input  logic                clk,
    input  logic                reset,
    f3m_serial_mult_if.slave    bus
);

    localparam int CW = $clog2(M);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2*M-1:0]     a_q, a_d;
    logic [2*M-1:0]     b_q, b_d;
    logic [2*M-1:0]     acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*M-1:0]     accNext;
    logic [1:0]         topDigit;
    logic [1:0]         curDigit;
    logic [1:0]         shifted;

    // Mod-3 addition of two digits. Illegal code 11 on an input still yields a
    // canonical digit, so the accumulator can never hold 11.
    function automatic logic [1:0] add3(input logic [1:0] x, input logic [1:0] y);
        logic [2:0] t;
        t = {1'b0, x} + {1'b0, y};
        if (t >= 3'd3) t = t - 3'd3;
        if (t >= 3'd3) t = t - 3'd3;
        return t[1:0];
    endfunction

    // Mod-3 product of a digit by a scalar digit; code 11 is treated as zero.
    function automatic logic [1:0] scale3(input logic [1:0] d, input logic [1:0] x);
        logic [1:0] r;
        r = 2'b00;
        if (x != 2'b11) begin
            case (d)
                2'b01:   r = x;
                2'b10:   r = {x[0], x[1]};
                default: r = 2'b00;
            endcase
        end
        return r;
    endfunction

    // Datapath: shift accumulator up one coefficient, fold the dropped top digit
    // back in via x^M = 2x^TAP + 1, then add the current B digit times A.
    always_comb begin
        accNext  = '0;
        shifted  = 2'b00;
        topDigit = acc_q[2*(M-1) +: 2];
        curDigit = b_q[2*int'(cnt_q) +: 2];
        for (int i = 0; i < M; i++) begin
            if (i == 0) begin
                shifted = topDigit;
            end else begin
                shifted = acc_q[2*(i-1) +: 2];
            end
            if (i == TAP) begin
                shifted = add3(shifted, scale3(2'b10, topDigit));
            end
            accNext[2*i +: 2] = add3(shifted, scale3(curDigit, a_q[2*i +: 2]));
        end
    end

    // Control: next-state and register loads; start is honoured only in IDLE or DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    acc_d   = '0;
                    cnt_d   = CW'(M - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = accNext;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset that abandons any run.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.C    = acc_q;
    assign bus.done = (state_q == DONE);

endmodule
